// File: rtl/aes_sub_bytes_engine.sv
// aes_sub_bytes_engine
//   Handshaked AES SubBytes engine. A 128-bit state is latched on accept and
//   its 16 bytes are pushed through LANES S-box units over 16/LANES passes.
//   The result register is written directly by the lanes. It therefore acts
//   as the registered lane output, and the full result is visible the cycle
//   after the last pass.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   source presents in_state/in_inv
//   in_ready   engine idle and able to accept
//   in_state   128-bit state, byte 15 = [127:120]
//   in_inv     0 = forward S-box, 1 = inverse S-box
//   out_valid  out_state holds a complete result
//   out_ready  consumer accepts out_state
//   out_state  substituted state, same byte order
module aes_sub_bytes_engine #(
  parameter int LANES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int PASSES = 16 / LANES;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   pass_cnt;
  logic [127:0]    in_reg;
  logic            inv_reg;
  logic [127:0]    result;
  logic [3:0]      lane_pos [LANES];
  logic [7:0]      lane_out [LANES];

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0; 0 maps to 0 naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic inv);
    return inv ? gf_inv(inv_affine(x)) : affine(gf_inv(x));
  endfunction

  // Lane k of pass p works on byte 15 - p*LANES - k (most significant first)
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_pos[k] = 4'(15 - int'(pass_cnt) * LANES - k);
      lane_out[k] = sub_byte(in_reg[lane_pos[k]*8 +: 8], inv_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      in_reg    <= '0;
      inv_reg   <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg   <= in_state;
            inv_reg  <= in_inv;
            pass_cnt <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < LANES; k++) begin
            result[lane_pos[k]*8 +: 8] <= lane_out[k];
          end
          if (pass_cnt == PW'(PASSES - 1)) begin
            out_valid <= 1'b1;
            state     <= DRAIN;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        // DRAIN is the first cycle the completed result is on out_state;
        // a waiting consumer can take it immediately.
        DRAIN, DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_state = result;

endmodule
